// File: rtl/instr_encode_loader.sv
// instr_encode_loader
// Packs MIPS R/I/J instruction fields into a 32-bit word and writes it to
// instruction memory at sequential byte addresses starting at BASE_ADDR.
// One field set is taken per handshake. The write is held on the port until
// mem_ready is seen. Loading stops after DEPTH words until clear or reset.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a field set (in_ready=1)
//   WRITE | encoded word presented on the memory port, waiting on mem_ready
//   DONE  | DEPTH words written; inputs ignored until clear or reset
module instr_encode_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   fmt,
   input  logic [5:0]                   opcode,
   input  logic [4:0]                   rs,
   input  logic [4:0]                   rt,
   input  logic [4:0]                   rd,
   input  logic [4:0]                   shamt,
   input  logic [5:0]                   funct,
   input  logic [15:0]                  imm16,
   input  logic [25:0]                  address,
   output logic                         mem_we,
   input  logic                         mem_ready,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   word_count,
   output logic                         done,
   output logic                         err_illegal
);

   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] FMT_R = 2'b00;
   localparam logic [1:0] FMT_I = 2'b01;
   localparam logic [1:0] FMT_J = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [31:0]   addr_q, addr_n;
   logic [31:0]   wdata_q, wdata_n;
   logic [CW-1:0] count_q, count_n;
   logic          err_q, err_n;
   logic [31:0]   enc_word;
   logic          fmt_legal;
   logic [CW-1:0] count_inc;

   // Field packing: plain concatenation, fields unused by the format are dropped.
   always_comb begin
      enc_word  = '0;
      fmt_legal = 1'b1;
      case (fmt)
         FMT_R:   enc_word = {opcode, rs, rt, rd, shamt, funct};
         FMT_I:   enc_word = {opcode, rs, rt, imm16};
         FMT_J:   enc_word = {opcode, address};
         default: fmt_legal = 1'b0;
      endcase
   end

   assign count_inc = count_q + CW'(1);

   // Next-state and datapath update; clear overrides any handshake or write.
   always_comb begin
      state_n = state;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      count_n = count_q;
      err_n   = 1'b0;
      if (clear) begin
         state_n = IDLE;
         addr_n  = BASE_ADDR;
         count_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (fmt_legal) begin
                     wdata_n = enc_word;
                     state_n = WRITE;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  count_n = count_inc;
                  addr_n  = addr_q + 32'd4;
                  state_n = (count_inc == CW'(DEPTH)) ? DONE : IDLE;
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         count_q <= count_n;
         err_q   <= err_n;
      end
   end

   // Outputs are decoded from registered state only, so in_valid never reaches mem_we.
   assign in_ready    = rst_n && (state == IDLE);
   assign mem_we      = (state == WRITE);
   assign done        = (state == DONE);
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign word_count  = count_q;
   assign err_illegal = err_q;

endmodule
